// File: rtl/catch_event_if.sv
// -----------------------------------------------------------------------------
// catch_event_if
//   Bundles the control inputs and the block/event outputs of catch_event_gen.
//   master : the event generator (drives block position and the event strobe)
//   slave  : the consumer side (frame timing / player input and score logic)
// Signals:
//   start        level, generator runs while high
//   frame_tick   one-cycle strobe per video frame
//   player_x     paddle left edge, pixels
//   block_x      falling block left edge
//   block_y      falling block top edge
//   block_active block visible
//   collision    event strobe, registered
//   color        event color code
// -----------------------------------------------------------------------------
interface catch_event_if;
  logic       start;
  logic       frame_tick;
  logic [9:0] player_x;
  logic [9:0] block_x;
  logic [9:0] block_y;
  logic       block_active;
  logic       collision;
  logic [1:0] color;

  modport master (
    input  start, frame_tick, player_x,
    output block_x, block_y, block_active, collision, color
  );

  modport slave (
    output start, frame_tick, player_x,
    input  block_x, block_y, block_active, collision, color
  );
endinterface

// File: rtl/catch_event_gen.sv
// -----------------------------------------------------------------------------
// catch_event_gen
//   Drops one falling block at a time, moves it FALL_STEP pixels per frame_tick,
//   detects a catch against the player paddle and emits a registered collision
//   pulse (PULSE_W clk wide) with a color code that is settled one full clk
//   before the pulse rises. The score accumulator clocks on posedge collision.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   ev   catch_event_if.master (start, frame_tick, player_x in;
//        block_x, block_y, block_active, collision, color out)
// Configuration macro:
//   MISS_PENALTY_EN  defined: a miss raises a red (2'b11) event pulse.
//                    undefined: a miss silently respawns the block.
// -----------------------------------------------------------------------------
module catch_event_gen #(
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned BLOCK_W   = 32,
  parameter int unsigned BLOCK_H   = 16,
  parameter int unsigned PLAYER_Y  = 440,
  parameter int unsigned X_MAX     = 608,
  parameter int unsigned FALL_STEP = 2,
  parameter int unsigned PULSE_W   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  catch_event_if.master   ev
);

  localparam int unsigned CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  localparam logic [10:0]      SCREEN_H_C  = 11'(SCREEN_H);
  localparam logic [10:0]      BLOCK_H_C   = 11'(BLOCK_H);
  localparam logic [10:0]      PLAYER_Y_C  = 11'(PLAYER_Y);
  localparam logic [10:0]      STEP_C      = 11'(FALL_STEP);
  localparam logic [11:0]      BLOCK_W_C   = 12'(BLOCK_W);
  localparam logic [9:0]       X_MAX_C     = 10'(X_MAX);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_SETUP = 3'd3,
    S_PULSE = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic fb;
    fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
    return {fb, cur[15:1]};
  endfunction

  state_t            state_r, state_s;
  logic [15:0]       lfsr_r;
  logic [1:0]        spawn_color_r, spawn_color_s;
  logic [CNT_W-1:0]  pulse_cnt_r, pulse_cnt_s;
  logic [9:0]        block_x_r, block_x_s;
  logic [9:0]        block_y_r, block_y_s;
  logic              block_active_r, block_active_s;
  logic              collision_r, collision_s;
  logic [1:0]        color_r, color_s;

  logic [9:0]        lfsr_x_s;
  logic [9:0]        spawn_x_s;
  logic [1:0]        lfsr_color_s;
  logic [10:0]       y_bot_s;
  logic [10:0]       y_next_s;
  logic signed [11:0] dx_s;
  logic [11:0]       dx_abs_s;
  logic              catch_s;
  logic              miss_s;

  // Spawn position folds LFSR values above X_MAX back into the legal range.
  assign lfsr_x_s     = lfsr_r[9:0];
  assign spawn_x_s    = (lfsr_x_s <= X_MAX_C) ? lfsr_x_s : (lfsr_x_s - X_MAX_C);
  assign lfsr_color_s = (lfsr_r[11:10] == 2'b00) ? 2'b01 : lfsr_r[11:10];

  // Geometry in 11/12-bit so neither the bottom edge nor the distance wraps.
  assign y_bot_s  = {1'b0, block_y_r} + BLOCK_H_C;
  assign y_next_s = {1'b0, block_y_r} + STEP_C;
  assign dx_s     = $signed({2'b00, block_x_r}) - $signed({2'b00, ev.player_x});
  assign dx_abs_s = dx_s[11] ? 12'(-dx_s) : 12'(dx_s);
  assign catch_s  = (y_bot_s >= PLAYER_Y_C) && ({1'b0, block_y_r} < PLAYER_Y_C) &&
                    (dx_abs_s < BLOCK_W_C);
  assign miss_s   = (y_next_s >= SCREEN_H_C);

  // LFSR free-runs every clock regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; ticks outside FALL are simply ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (ev.start) begin
          state_s = S_SPAWN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SPAWN: begin
        state_s = S_FALL;
      end
      S_FALL: begin
        if (ev.frame_tick) begin
          if (catch_s) begin
            state_s = S_SETUP;
          end else if (miss_s) begin
`ifdef MISS_PENALTY_EN
            state_s = S_SETUP;
`else
            state_s = S_GAP;
`endif
          end else begin
            state_s = S_FALL;
          end
        end else begin
          state_s = S_FALL;
        end
      end
      S_SETUP: begin
        state_s = S_PULSE;
      end
      S_PULSE: begin
        if (pulse_cnt_r == PULSE_LAST) begin
          state_s = S_GAP;
        end else begin
          state_s = S_PULSE;
        end
      end
      S_GAP: begin
        if (ev.start) begin
          state_s = S_SPAWN;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values; outputs are decoded from the next state so
  // that every port comes straight from a flop.
  always_comb begin
    block_x_s      = block_x_r;
    block_y_s      = block_y_r;
    color_s        = color_r;
    spawn_color_s  = spawn_color_r;
    pulse_cnt_s    = '0;
    block_active_s = (state_s == S_FALL);
    collision_s    = (state_s == S_PULSE);
    case (state_r)
      S_SPAWN: begin
        block_x_s     = spawn_x_s;
        block_y_s     = 10'd0;
        spawn_color_s = lfsr_color_s;
      end
      S_FALL: begin
        if (state_s == S_SETUP) begin
          // A caught block reports its own color; a miss here is the penalty.
          color_s = catch_s ? spawn_color_r : 2'b11;
        end else if (ev.frame_tick && !miss_s) begin
          block_y_s = y_next_s[9:0];
        end else begin
          block_y_s = block_y_r;
        end
      end
      S_PULSE: begin
        pulse_cnt_s = pulse_cnt_r + CNT_W'(1);
      end
      default: begin
        pulse_cnt_s = '0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_x_r      <= 10'd0;
      block_y_r      <= 10'd0;
      block_active_r <= 1'b0;
      collision_r    <= 1'b0;
      color_r        <= 2'b00;
      spawn_color_r  <= 2'b01;
      pulse_cnt_r    <= '0;
    end else begin
      block_x_r      <= block_x_s;
      block_y_r      <= block_y_s;
      block_active_r <= block_active_s;
      collision_r    <= collision_s;
      color_r        <= color_s;
      spawn_color_r  <= spawn_color_s;
      pulse_cnt_r    <= pulse_cnt_s;
    end
  end

  assign ev.block_x      = block_x_r;
  assign ev.block_y      = block_y_r;
  assign ev.block_active = block_active_r;
  assign ev.collision    = collision_r;
  assign ev.color        = color_r;

endmodule

// File: tb/tb_catch_event_gen.sv
// -----------------------------------------------------------------------------
// tb_catch_event_gen
//   Randomized stimulus against a behavioural game model. Expected event colors
//   go into a queue when the model predicts an event; a monitor pops them on
//   each collision rising edge and also checks color setup and pulse width.
// -----------------------------------------------------------------------------
module tb_catch_event_gen;

  localparam int SCREEN_H  = 480;
  localparam int BLOCK_W   = 32;
  localparam int BLOCK_H   = 16;
  localparam int PLAYER_Y  = 440;
  localparam int X_MAX     = 608;
  localparam int FALL_STEP = 2;
  localparam int PULSE_W   = 4;
  localparam int SEED      = 'hACE1;
  localparam int N_CYCLES  = 20000;

  localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_SETUP = 3, P_PULSE = 4, P_GAP = 5;

  logic clk;
  logic rst;
  catch_event_if ev ();

  catch_event_gen dut (
    .clk (clk),
    .rst (rst),
    .ev  (ev.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_events = 0;
  int exp_q[$];

  // model state
  int m_lfsr, m_phase, m_bx, m_by, m_color, m_spawn_col, m_left;
  // stimulus state
  int px_v, start_off;
  bit start_v, tick_v, tick_dense, draining;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_phase = P_IDLE; m_bx = 0; m_by = 0; m_color = 0;
    m_spawn_col = 1; m_left = 0;
  endtask

  task automatic pick_player();
    int mode, p;
    mode = $urandom_range(0, 5);
    case (mode)
      0: p = m_bx;
      1: p = m_bx + BLOCK_W - 1;
      2: p = m_bx - (BLOCK_W - 1);
      3: p = m_bx + BLOCK_W;
      4: p = m_bx - BLOCK_W;
      default: p = $urandom_range(0, 1023);
    endcase
    if (p < 0 || p > 1023) p = $urandom_range(0, 1023);
    px_v = p;
    tick_dense = ($urandom_range(0, 2) == 0);
  endtask

  // One clock of the game rules, from the values seen on the inputs.
  task automatic model_step();
    int l10, d, fb;
    case (m_phase)
      P_IDLE: if (start_v) m_phase = P_SPAWN;
      P_SPAWN: begin
        l10 = m_lfsr % 1024;
        m_bx = (l10 <= X_MAX) ? l10 : l10 - X_MAX;
        m_by = 0;
        m_spawn_col = (m_lfsr / 1024) % 4;
        if (m_spawn_col == 0) m_spawn_col = 1;
        m_phase = P_FALL;
        pick_player();
      end
      P_FALL: if (tick_v) begin
        d = m_bx - px_v;
        if (d < 0) d = -d;
        if (m_by + BLOCK_H >= PLAYER_Y && m_by < PLAYER_Y && d < BLOCK_W) begin
          m_color = m_spawn_col;
          exp_q.push_back(m_color);
          m_phase = P_SETUP;
        end else if (m_by + FALL_STEP >= SCREEN_H) begin
`ifdef MISS_PENALTY_EN
          m_color = 3;
          exp_q.push_back(m_color);
          m_phase = P_SETUP;
`else
          m_phase = P_GAP;
`endif
        end else begin
          m_by = m_by + FALL_STEP;
        end
      end
      P_SETUP: begin m_phase = P_PULSE; m_left = PULSE_W; end
      P_PULSE: begin m_left--; if (m_left == 0) m_phase = P_GAP; end
      P_GAP: m_phase = start_v ? P_SPAWN : P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    m_lfsr = (m_lfsr >> 1) | (fb << 15);
  endtask

  task automatic drive_inputs();
    if (draining) start_v = 1'b0;
    else if (start_off > 0) begin start_off--; start_v = 1'b0; end
    else if ($urandom_range(0, 999) == 0) begin start_off = $urandom_range(20, 400); start_v = 1'b0; end
    else start_v = 1'b1;
    tick_v = tick_dense ? 1'b1 : ($urandom_range(0, 3) == 0);
    ev.start      = start_v;
    ev.frame_tick = tick_v;
    ev.player_x   = px_v[9:0];
  endtask

  task automatic compare_outputs();
    chk("block_x", int'(ev.block_x), m_bx);
    chk("block_y", int'(ev.block_y), m_by);
    chk("block_active", int'(ev.block_active), (m_phase == P_FALL) ? 1 : 0);
    chk("collision", int'(ev.collision), (m_phase == P_PULSE) ? 1 : 0);
    chk("color", int'(ev.color), m_color);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_block_x"}, int'(ev.block_x), 0);
    chk({tag, "_block_y"}, int'(ev.block_y), 0);
    chk({tag, "_active"}, int'(ev.block_active), 0);
    chk({tag, "_collision"}, int'(ev.collision), 0);
    chk({tag, "_color"}, int'(ev.color), 0);
  endtask

  // Scoreboard monitor: pops one expected color per collision rising edge.
  initial begin
    bit prev_col;
    int prev_color, hi_cnt, exp_c;
    prev_col = 1'b0; prev_color = 0; hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi_cnt = 0;
      end else if (ev.collision && !prev_col) begin
        n_events++;
        hi_cnt = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          exp_c = exp_q.pop_front();
          chk("event_color", int'(ev.color), exp_c);
          chk("color_setup", prev_color, exp_c);
        end
      end else if (ev.collision) begin
        hi_cnt++;
      end else if (prev_col) begin
        chk("pulse_width", hi_cnt, PULSE_W);
      end else begin
        hi_cnt = 0;
      end
      prev_col = ev.collision;
      prev_color = int'(ev.color);
    end
  end

  task automatic one_cycle();
    drive_inputs();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  initial begin
    bit rst_pulse_done, rst_fall_done;
    int guard;
    rst = 1'b1;
    start_v = 1'b0; tick_v = 1'b0; px_v = 0; start_off = 0;
    tick_dense = 1'b0; draining = 1'b0;
    ev.start = 1'b0; ev.frame_tick = 1'b0; ev.player_x = 10'd0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rst_pulse_done = 1'b0; rst_fall_done = 1'b0;
    for (int i = 0; i < N_CYCLES; i++) begin
      one_cycle();
      if ((!rst_pulse_done && i > 8000 && m_phase == P_PULSE) ||
          (!rst_fall_done && i > 14000 && m_phase == P_FALL && m_by > 0)) begin
        if (m_phase == P_PULSE) rst_pulse_done = 1'b1;
        else rst_fall_done = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    // Drain: drop start and let the block in flight finish.
    draining = 1'b1;
    guard = 0;
    while (m_phase != P_IDLE && guard < 3000) begin
      one_cycle();
      @(negedge clk);
      guard++;
    end
    chk("drain_to_idle", m_phase, P_IDLE);
    repeat (3) begin
      one_cycle();
      @(negedge clk);
    end
    chk("queue_empty", exp_q.size(), 0);
    chk("events_seen", (n_events > 10) ? 1 : 0, 1);
    chk("mid_rst_pulse_hit", int'(rst_pulse_done), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
